// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester-side request/response bundle for alu_arbiter
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0;
  logic [31:0] req_b0;
  logic [31:0] req_a1;
  logic [31:0] req_b1;
  logic [1:0]  req_width0;
  logic [1:0]  req_width1;
  logic        req_sat0;
  logic        req_sat1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1,
           req_width0, req_width1, req_sat0, req_sat1, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1,
           req_width0, req_width1, req_sat0, req_sat1, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port round-robin sequencer sharing one combinational SIMD alu
module alu_arbiter (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  output logic [1:0]    alu_width,
  output logic          alu_saturate,
  input  logic [31:0]   alu_c,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        grant;
  logic        prio;
  logic [1:0]  req_ready_c;
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic        accept;
  logic        sel;

  // Only one port may see ready, so an accept always has an unambiguous winner.
  always_comb begin
    req_ready_c = 2'b00;
    if (state == IDLE) begin
      case (bus.req_valid)
        2'b01:   req_ready_c = 2'b01;
        2'b10:   req_ready_c = 2'b10;
        2'b11:   req_ready_c = prio ? 2'b10 : 2'b01;
        default: req_ready_c = 2'b00;
      endcase
    end
  end

  assign accept        = |(bus.req_valid & req_ready_c);
  assign sel           = req_ready_c[1];
  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant        <= 1'b0;
      prio         <= 1'b0;
      rsp_valid_q  <= 2'b00;
      rsp_data_q   <= 32'd0;
      alu_a        <= 32'd0;
      alu_b        <= 32'd0;
      alu_width    <= 2'b00;
      alu_saturate <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a        <= sel ? bus.req_a1 : bus.req_a0;
            alu_b        <= sel ? bus.req_b1 : bus.req_b0;
            alu_width    <= sel ? bus.req_width1 : bus.req_width0;
            alu_saturate <= sel ? bus.req_sat1 : bus.req_sat0;
            grant        <= sel;
            busy         <= 1'b1;
            state        <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_c;
          rsp_valid_q <= grant ? 2'b10 : 2'b01;
          state       <= RESP;
        end
        RESP: begin
          // The loser of this round becomes favoured, giving strict alternation under load.
          if (bus.rsp_ready[grant]) begin
            prio        <= ~grant;
            rsp_valid_q <= 2'b00;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural SIMD alu
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [1:0]  alu_width;
  logic        alu_saturate;
  logic        busy;
  int          errors = 0;
  int          checks = 0;

  alu_arbiter_if ifc();

  alu_arbiter dut (
    .clk(clk), .rst(rst), .bus(ifc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_width(alu_width),
    .alu_saturate(alu_saturate), .alu_c(alu_c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Signed lane-wise add with optional clamping; width 11 behaves as 32-bit.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] w, input logic s);
    int lw;
    longint mask, half, ua, ub, av, bv, sum;
    logic [31:0] r;
    lw   = (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
    mask = (64'sd1 <<< lw) - 1;
    half = 64'sd1 <<< (lw - 1);
    r    = 32'd0;
    for (int l = 0; l < 32 / lw; l++) begin
      ua  = longint'({32'd0, a}) >>> (l * lw) & mask;
      ub  = longint'({32'd0, b}) >>> (l * lw) & mask;
      av  = (ua >= half) ? ua - (mask + 1) : ua;
      bv  = (ub >= half) ? ub - (mask + 1) : ub;
      sum = av + bv;
      if (s && sum > half - 1) sum = half - 1;
      if (s && sum < -half)    sum = -half;
      r = r | 32'((sum & mask) << (l * lw));
    end
    return r;
  endfunction

  always_comb alu_c = alu_ref(alu_a, alu_b, alu_width, alu_saturate);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_port(input int p, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] w, input logic s);
    if (p == 0) begin
      ifc.req_a0 = a; ifc.req_b0 = b; ifc.req_width0 = w; ifc.req_sat0 = s;
    end else begin
      ifc.req_a1 = a; ifc.req_b1 = b; ifc.req_width1 = w; ifc.req_sat1 = s;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    ifc.req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  w;
    logic        s;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic run_vec(input vec_t v);
    logic [1:0] oh;
    oh = (v.port == 0) ? 2'b01 : 2'b10;
    drive_port(v.port, v.a, v.b, v.w, v.s);
    ifc.req_valid = oh;
    #1;
    check("vec_req_ready", 32'(ifc.req_ready), 32'(oh));
    check("vec_rsp_idle", 32'(ifc.rsp_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    ifc.req_valid = 2'b00;
    #1;
    check("vec_exec_busy", 32'(busy), 32'd1);
    check("vec_exec_ready", 32'(ifc.req_ready), 32'd0);
    check("vec_exec_rsp", 32'(ifc.rsp_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    #1;
    check("vec_rsp_valid", 32'(ifc.rsp_valid), 32'(oh));
    check("vec_rsp_data", ifc.rsp_data, v.exp);
    @(posedge clk); @(negedge clk);
    #1;
    check("vec_done_valid", 32'(ifc.rsp_valid), 32'd0);
    check("vec_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int acc_cyc[$];
    int acc_port[$];
    int cyc;
    logic        pend[2];
    logic [31:0] pa[2], pb[2];
    logic [1:0]  pw[2];
    logic        ps[2];
    logic        in_flight;
    int          age, gport, mprio, win;
    logic [31:0] exp_d;
    logic [1:0]  exp_rr, exp_rv;

    vecs[0] = '{0, 32'h7F7F7F7F, 32'h01010101, 2'b00, 1'b1, 32'h7F7F7F7F};
    vecs[1] = '{0, 32'h7F7F7F7F, 32'h01010101, 2'b00, 1'b0, 32'h80808080};
    vecs[2] = '{1, 32'h7FFF8000, 32'h0001FFFF, 2'b01, 1'b1, 32'h7FFF8000};
    vecs[3] = '{1, 32'h7FFF8000, 32'h0001FFFF, 2'b01, 1'b0, 32'h80007FFF};
    vecs[4] = '{0, 32'h7FFFFFFF, 32'h00000001, 2'b10, 1'b1, 32'h7FFFFFFF};
    vecs[5] = '{1, 32'h7FFFFFFF, 32'h00000001, 2'b10, 1'b0, 32'h80000000};
    vecs[6] = '{0, 32'h80808080, 32'hFFFFFFFF, 2'b00, 1'b1, 32'h80808080};
    vecs[7] = '{1, 32'h80808080, 32'hFFFFFFFF, 2'b00, 1'b0, 32'h7F7F7F7F};
    vecs[8] = '{1, 32'hFFFFFFFF, 32'h00000001, 2'b11, 1'b0, 32'h00000000};
    vecs[9] = '{0, 32'h12345678, 32'h11111111, 2'b11, 1'b1, 32'h23456789};

    rst = 1'b1;
    ifc.req_valid = 2'b00;
    ifc.rsp_ready = 2'b11;
    drive_port(0, 0, 0, 0, 0);
    drive_port(1, 0, 0, 0, 0);
    do_reset();
    #1;
    check("rst_req_ready", 32'(ifc.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check("rst_rsp_data", ifc.rsp_data, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_ctl", {29'd0, alu_width, alu_saturate}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Idle: alu outputs keep the last request's operands.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ready", 32'(ifc.req_ready), 32'd0);
      check("idle_alu_a", alu_a, vecs[9].a);
      check("idle_alu_b", alu_b, vecs[9].b);
      check("idle_alu_ctl", {29'd0, alu_width, alu_saturate}, {29'd0, vecs[9].w, vecs[9].s});
    end

    // Continuous load on both ports alternates grants every 3 cycles.
    do_reset();
    drive_port(0, 1, 1, 2'b10, 1'b0);
    drive_port(1, 2, 2, 2'b10, 1'b0);
    ifc.req_valid = 2'b11;
    ifc.rsp_ready = 2'b11;
    cyc = 0;
    while (acc_port.size() < 4 && cyc < 60) begin
      #1;
      if (ifc.req_ready != 2'b00) begin
        acc_cyc.push_back(cyc);
        acc_port.push_back(int'(ifc.req_ready[1]));
      end
      if (ifc.rsp_valid != 2'b00)
        check("alt_rsp_data", ifc.rsp_data, ifc.rsp_valid[1] ? 32'd4 : 32'd2);
      @(negedge clk);
      cyc++;
    end
    check("alt_accept_count", 32'(acc_port.size()), 32'd4);
    if (acc_port.size() == 4) begin
      for (int i = 0; i < 4; i++) check("alt_grant", 32'(acc_port[i]), 32'(i % 2));
      for (int i = 1; i < 4; i++) check("alt_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
    end
    ifc.req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // Back-pressure on port 1 while port 0 waits.
    do_reset();
    drive_port(1, 32'h11223344, 32'h01010101, 2'b00, 1'b0);
    drive_port(0, 32'h55555555, 32'h00000001, 2'b10, 1'b0);
    ifc.req_valid = 2'b10;
    ifc.rsp_ready = 2'b01;
    @(posedge clk); @(negedge clk);
    ifc.req_valid = 2'b01;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_rsp_valid", 32'(ifc.rsp_valid), 32'd2);
      check("bp_rsp_data", ifc.rsp_data, 32'h12233445);
      check("bp_req_ready", 32'(ifc.req_ready), 32'd0);
      check("bp_alu_a", alu_a, 32'h11223344);
      @(negedge clk);
    end
    ifc.rsp_ready = 2'b11;
    ifc.req_valid = 2'b00;
    #1;
    check("bp_hold_edge", 32'(ifc.rsp_valid), 32'd2);
    @(posedge clk); @(negedge clk); #1;
    check("bp_done_valid", 32'(ifc.rsp_valid), 32'd0);
    check("bp_done_busy", 32'(busy), 32'd0);

    // Reset during EXEC.
    do_reset();
    drive_port(0, 32'hDEADBEEF, 32'h1, 2'b10, 1'b0);
    ifc.req_valid = 2'b01;
    @(posedge clk); @(negedge clk);
    ifc.req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rexec_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check("rexec_busy", 32'(busy), 32'd0);
    check("rexec_alu_a", alu_a, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("rexec_no_rsp", 32'(ifc.rsp_valid), 32'd0);
    end

    // Reset during RESP after port 0 was served, so prio must fall back to 0.
    run_vec(vecs[0]);
    ifc.rsp_ready = 2'b00;
    drive_port(1, 32'hCAFEF00D, 32'h1, 2'b10, 1'b0);
    ifc.req_valid = 2'b10;
    @(posedge clk); @(negedge clk);
    ifc.req_valid = 2'b00;
    @(posedge clk); @(negedge clk); #1;
    check("rresp_pre_valid", 32'(ifc.rsp_valid), 32'd2);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("rresp_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    check("rresp_busy", 32'(busy), 32'd0);
    check("rresp_alu_a", alu_a, 32'd0);
    ifc.req_valid = 2'b11;
    #1;
    check("rresp_prio0", 32'(ifc.req_ready), 32'd1);
    ifc.req_valid = 2'b00;

    // Random traffic against a transaction-level model.
    do_reset();
    pend = '{1'b0, 1'b0};
    in_flight = 1'b0; age = 0; gport = 0; mprio = 0; exp_d = 32'd0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pa[i] = $urandom; pb[i] = $urandom;
          pw[i] = 2'($urandom_range(0, 3)); ps[i] = 1'($urandom_range(0, 1));
        end
      end
      drive_port(0, pa[0], pb[0], pw[0], ps[0]);
      drive_port(1, pa[1], pb[1], pw[1], ps[1]);
      ifc.req_valid = {pend[1], pend[0]};
      ifc.rsp_ready = 2'($urandom_range(0, 3));
      #1;
      win = (pend[0] && pend[1]) ? mprio : pend[0] ? 0 : pend[1] ? 1 : -1;
      exp_rr = (!in_flight && win >= 0) ? 2'(1 << win) : 2'b00;
      exp_rv = (in_flight && age >= 1) ? 2'(1 << gport) : 2'b00;
      check("rnd_req_ready", 32'(ifc.req_ready), 32'(exp_rr));
      check("rnd_rsp_valid", 32'(ifc.rsp_valid), 32'(exp_rv));
      if (exp_rv != 2'b00) check("rnd_rsp_data", ifc.rsp_data, exp_d);
      if (!in_flight) begin
        if (win >= 0) begin
          in_flight = 1'b1; age = 0; gport = win;
          exp_d = alu_ref(pa[win], pb[win], pw[win], ps[win]);
          pend[win] = 1'b0;
        end
      end else if (age == 0) begin
        age = 1;
      end else if (ifc.rsp_ready[gport]) begin
        in_flight = 1'b0;
        mprio = 1 - gport;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
